// File: rtl/busio_pkg.sv
// Shared definitions for the busio block: bus widths, arbiter state encoding
// and the saturating starvation-counter helper.
package busio_pkg;

  // Default widths of the external memory bus, also used by the bus adapter.
  localparam int BUS_ADDR_WIDTH = 32;
  localparam int BUS_DATA_WIDTH = 32;
  localparam int BUS_STRB_WIDTH = BUS_DATA_WIDTH / 8;

  // Arbiter state encoding (kept as plain constants for legacy tools).
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;

  // Fetch anti-starvation counter.
  typedef logic [3:0] starve_cnt_t;

  // Increment that stops at the configured limit.
  function automatic starve_cnt_t starve_inc(input starve_cnt_t cnt, input starve_cnt_t limit);
    return (cnt >= limit) ? cnt : cnt + starve_cnt_t'(1);
  endfunction

endpackage

// File: rtl/busio_arbiter.sv
// Shares the single external memory port between instruction fetch and the
// memory stage. One transaction in flight; data has priority, bounded by a
// fetch anti-starvation counter. A fetch whose address is redirected while on
// the bus is completed silently and immediately reissued.
module busio_arbiter
  import busio_pkg::*;
#(
  parameter int ADDR_WIDTH   = BUS_ADDR_WIDTH,
  parameter int DATA_WIDTH   = BUS_DATA_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  // instruction fetch side
  input  logic                    fetch_request,
  input  logic [ADDR_WIDTH-1:0]   fetch_address,
  output logic [DATA_WIDTH-1:0]   fetch_data,
  output logic                    fetch_ready,
  // memory stage side
  input  logic                    mem_request,
  input  logic                    mem_write,
  input  logic [ADDR_WIDTH-1:0]   mem_address,
  input  logic [DATA_WIDTH-1:0]   mem_write_data,
  input  logic [DATA_WIDTH/8-1:0] mem_strobe,
  output logic [DATA_WIDTH-1:0]   mem_read_data,
  output logic                    mem_ready,
  // external bus
  output logic                    ext_valid,
  output logic                    ext_write,
  output logic [ADDR_WIDTH-1:0]   ext_address,
  output logic [DATA_WIDTH-1:0]   ext_write_data,
  output logic [DATA_WIDTH/8-1:0] ext_strobe,
  input  logic                    ext_ready,
  input  logic [DATA_WIDTH-1:0]   ext_read_data
);

  localparam int          STRB_WIDTH = DATA_WIDTH / 8;
  localparam starve_cnt_t LIMIT      = starve_cnt_t'(STARVE_LIMIT);

  logic [1:0]            state_reg, state_next;
  starve_cnt_t           starve_cnt_reg, starve_cnt_next;
  logic                  stale_reg, stale_next;

  logic                  busy;
  logic                  complete;
  logic                  arbitrate;
  logic                  redirect;
  logic                  stale_now;
  logic                  fetch_cand;
  logic                  mem_cand;
  logic                  grant_fetch;
  logic                  grant_data;
  logic                  store_grant;
  logic [STRB_WIDTH-1:0] grant_strobe;

  // The bus request is simply "a transaction is in flight"; it drops with reset.
  assign ext_valid = busy;

  // Completion, redirect detection, requester exclusion and the grant decision.
  always_comb begin
    busy      = (state_reg != IDLE);
    complete  = busy && ext_ready;
    arbitrate = !busy || complete;

    // A fetch is stale if the pipeline dropped or moved it while it was on the bus,
    // including a change seen in the completion cycle itself.
    redirect  = (state_reg == FETCH) &&
                (!fetch_request || (fetch_address != ext_address));
    stale_now = stale_reg || redirect;

    fetch_ready   = complete && (state_reg == FETCH) && !stale_now;
    mem_ready     = complete && (state_reg == DATA);
    fetch_data    = ext_read_data;
    mem_read_data = ext_read_data;

    // The requester completing now still shows its old request; ignore it.
    // A dropped stale fetch is not excluded, so a redirected address goes out at once.
    fetch_cand = fetch_request && !fetch_ready;
    mem_cand   = mem_request && !mem_ready;

    grant_fetch = arbitrate && fetch_cand && (!mem_cand || (starve_cnt_reg == LIMIT));
    grant_data  = arbitrate && !grant_fetch && mem_cand;
    store_grant = grant_data && mem_write;
  end

  // Reads always present a full-width strobe; stores pass the byte enables through.
  generate
    for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_strobe
      assign grant_strobe[gi] = !store_grant || mem_strobe[gi];
    end
  endgenerate

  // Next state, starvation counter and stale flag.
  always_comb begin
    state_next      = state_reg;
    starve_cnt_next = starve_cnt_reg;
    stale_next      = stale_reg;

    if (grant_fetch) begin
      state_next = FETCH;
    end else if (grant_data) begin
      state_next = DATA;
    end else if (arbitrate) begin
      state_next = IDLE;
    end

    // Count only data grants that actually made a waiting fetch wait longer.
    if (grant_fetch) begin
      starve_cnt_next = '0;
    end else if (grant_data && fetch_cand) begin
      starve_cnt_next = starve_inc(starve_cnt_reg, LIMIT);
    end else if (!busy && !fetch_request) begin
      starve_cnt_next = '0;
    end

    if (grant_fetch || grant_data) begin
      stale_next = 1'b0;
    end else if (redirect) begin
      stale_next = 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= '0;
      stale_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
      stale_reg      <= stale_next;
    end
  end

  // Bus fields are captured only at a grant and held until the next one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_write      <= 1'b0;
      ext_address    <= '0;
      ext_write_data <= '0;
      ext_strobe     <= '0;
    end else if (grant_fetch || grant_data) begin
      ext_write      <= store_grant;
      ext_address    <= grant_fetch ? fetch_address : mem_address;
      ext_write_data <= grant_data ? mem_write_data : '0;
      ext_strobe     <= grant_strobe;
    end
  end

endmodule

// File: tb/tb_busio_arbiter.sv
// Scoreboard bench for busio_arbiter: stimulus pushes expected grants and
// responses; a monitor pops and compares whenever the DUT presents them.
module tb_busio_arbiter;
  import busio_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_request;
  logic [31:0] fetch_address;
  logic [31:0] fetch_data;
  logic        fetch_ready;
  logic        mem_request;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_strobe;
  logic [31:0] mem_read_data;
  logic        mem_ready;
  logic        ext_valid;
  logic        ext_write;
  logic [31:0] ext_address;
  logic [31:0] ext_write_data;
  logic [3:0]  ext_strobe;
  logic        ext_ready;
  logic [31:0] ext_read_data;

  busio_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .fetch_request(fetch_request), .fetch_address(fetch_address),
    .fetch_data(fetch_data), .fetch_ready(fetch_ready),
    .mem_request(mem_request), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_strobe(mem_strobe),
    .mem_read_data(mem_read_data), .mem_ready(mem_ready),
    .ext_valid(ext_valid), .ext_write(ext_write), .ext_address(ext_address),
    .ext_write_data(ext_write_data), .ext_strobe(ext_strobe),
    .ext_ready(ext_ready), .ext_read_data(ext_read_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strobe;
  } grant_t;

  typedef struct packed {
    logic        is_fetch;
    logic [31:0] data;
  } resp_t;

  grant_t grant_q[$];
  resp_t  resp_q[$];
  int     n_checks = 0;
  int     n_pass = 0;
  int     slave_lat = 1;
  bit     force_ready = 1'b0;
  int     mem_ready_pulses = 0;

  // Slave read data is a fixed function of the address.
  function automatic logic [31:0] rd_for(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_checks++;
    $display("FAIL %s: no response within cycle budget, expected one", name);
  endtask

  task automatic push_grant(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
    grant_t g;
    g.write = w; g.addr = a; g.wdata = d; g.strobe = s;
    grant_q.push_back(g);
  endtask

  task automatic push_resp(input logic f, input logic [31:0] d);
    resp_t r;
    r.is_fetch = f; r.data = d;
    resp_q.push_back(r);
  endtask

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  // what: 0 = mem_ready, 1 = fetch_ready, 2 = ext_ready. Returns at #2 in the hit cycle.
  task automatic wait_for(input int what, input string name, output int cycles);
    cycles = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #2;
      if ((what == 0 && mem_ready) || (what == 1 && fetch_ready) || (what == 2 && ext_ready)) begin
        cycles = i;
        return;
      end
    end
    timeout(name);
  endtask

  // Slave model: ext_ready after slave_lat wait cycles of ext_valid.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    ext_ready = 1'b0;
    ext_read_data = '0;
    forever begin
      @(posedge clk); #1;
      ext_ready = 1'b0;
      if (force_ready) begin
        ext_ready = 1'b1;
        ext_read_data = 32'hFFFF_0000;
      end else if (ext_valid && !reset) begin
        if (wait_cnt >= slave_lat) begin
          ext_ready = 1'b1;
          ext_read_data = rd_for(ext_address);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: new grants, bus-field stability, and ready responses.
  initial begin
    grant_t cur;
    resp_t  r;
    bit     valid_prev;
    bit     ready_prev;
    cur = '0;
    valid_prev = 1'b0;
    ready_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        valid_prev = 1'b0;
        ready_prev = 1'b0;
      end else begin
        if (ext_valid && (!valid_prev || ready_prev)) begin
          if (grant_q.size() == 0) begin
            n_checks++;
            $display("FAIL grant_unexpected: got grant addr=0x%08h, expected none", ext_address);
          end else begin
            cur = grant_q.pop_front();
            chk("grant_write", ext_write, cur.write);
            chk("grant_addr", ext_address, cur.addr);
            chk("grant_strobe", ext_strobe, cur.strobe);
            if (cur.write) chk("grant_wdata", ext_write_data, cur.wdata);
            $display("grant %s addr=0x%08h strobe=%b", ext_write ? "store" : "read",
                     ext_address, ext_strobe);
          end
        end else if (ext_valid) begin
          chk("hold_addr", ext_address, cur.addr);
          chk("hold_write", ext_write, cur.write);
          chk("hold_strobe", ext_strobe, cur.strobe);
        end
        if (fetch_ready || mem_ready) begin
          if (fetch_ready && mem_ready) begin
            n_checks++;
            $display("FAIL both_ready: got fetch_ready=1 mem_ready=1, expected one");
          end else if (resp_q.size() == 0) begin
            n_checks++;
            $display("FAIL resp_unexpected: got fetch_ready=%0b mem_ready=%0b, expected none",
                     fetch_ready, mem_ready);
          end else begin
            r = resp_q.pop_front();
            chk("resp_kind", fetch_ready, r.is_fetch);
            chk("resp_data", fetch_ready ? fetch_data : mem_read_data, r.data);
            $display("%s done data=0x%08h", fetch_ready ? "fetch" : "mem", 
                     fetch_ready ? fetch_data : mem_read_data);
          end
          if (mem_ready) mem_ready_pulses++;
        end
        valid_prev = ext_valid;
        ready_prev = ext_ready;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int held;
    int pulses0;
    bit seen;
    reset = 1'b1;
    fetch_request = 1'b0; fetch_address = '0;
    mem_request = 1'b0; mem_write = 1'b0; mem_address = '0;
    mem_write_data = '0; mem_strobe = '0;

    // Reset state
    cycle(); cycle();
    chk("rst_ext_valid", ext_valid, 0);
    chk("rst_ext_write", ext_write, 0);
    chk("rst_ext_address", ext_address, 0);
    chk("rst_ext_wdata", ext_write_data, 0);
    chk("rst_ext_strobe", ext_strobe, 0);
    chk("rst_fetch_ready", fetch_ready, 0);
    chk("rst_mem_ready", mem_ready, 0);
    reset = 1'b0;
    cycle();

    // Fetch only, slave answers one cycle after ext_valid
    slave_lat = 1;
    fetch_address = 32'h100; fetch_request = 1'b1;
    push_grant(1'b0, 32'h100, 32'h0, 4'hF);
    push_resp(1'b1, rd_for(32'h100));
    wait_for(1, "fetch_only", lat);
    chk("fetch_latency", lat, 2);
    cycle();
    chk("fetch_no_regrant", ext_valid, 0);
    fetch_request = 1'b0;
    cycle();

    // ext_ready while idle is ignored
    force_ready = 1'b1;
    @(posedge clk); #2;
    chk("idle_ready_fetch", fetch_ready, 0);
    chk("idle_ready_mem", mem_ready, 0);
    force_ready = 1'b0;
    cycle();
    chk("idle_ready_valid", ext_valid, 0);

    // Simultaneous request: data first, then fetch with no idle bus cycle
    fetch_address = 32'h200; fetch_request = 1'b1;
    mem_address = 32'h8000; mem_write = 1'b0; mem_strobe = 4'h1;
    mem_write_data = 32'h1111_2222; mem_request = 1'b1;
    push_grant(1'b0, 32'h8000, 32'h0, 4'hF);
    push_grant(1'b0, 32'h200, 32'h0, 4'hF);
    push_resp(1'b0, rd_for(32'h8000));
    push_resp(1'b1, rd_for(32'h200));
    wait_for(0, "simul_data", lat);
    cycle();
    mem_request = 1'b0;
    chk("simul_no_idle", ext_valid, 1);
    chk("simul_fetch_addr", ext_address, 32'h200);
    wait_for(1, "simul_fetch", lat);
    cycle();
    fetch_request = 1'b0;
    cycle();

    // Starvation: four data grants while fetch waits, then fetch, then data again
    fetch_address = 32'h500; fetch_request = 1'b1;
    mem_address = 32'hC000; mem_request = 1'b1;
    push_grant(1'b0, 32'hC000, 32'h0, 4'hF);
    push_resp(1'b0, rd_for(32'hC000));
    for (int i = 0; i < 4; i++) begin
      wait_for(0, "starve_data", lat);
      fetch_request = 1'b0;
      cycle();
      fetch_request = 1'b1;
      mem_address = 32'hC000 + 32'((i + 1) * 16);
      if (i < 3) begin
        push_grant(1'b0, mem_address, 32'h0, 4'hF);
        push_resp(1'b0, rd_for(mem_address));
      end else begin
        push_grant(1'b0, 32'h500, 32'h0, 4'hF);
        push_resp(1'b1, rd_for(32'h500));
        push_grant(1'b0, 32'hC040, 32'h0, 4'hF);
        push_resp(1'b0, rd_for(32'hC040));
      end
    end
    wait_for(1, "starve_fetch", lat);
    cycle();
    fetch_request = 1'b0;
    wait_for(0, "starve_resume", lat);
    cycle();
    mem_request = 1'b0;
    cycle();

    // Redirect: 0x300 in flight, moved to 0x400
    slave_lat = 3;
    fetch_address = 32'h300; fetch_request = 1'b1;
    push_grant(1'b0, 32'h300, 32'h0, 4'hF);
    push_grant(1'b0, 32'h400, 32'h0, 4'hF);
    push_resp(1'b1, rd_for(32'h400));
    cycle(); cycle();
    fetch_address = 32'h400;
    wait_for(2, "redirect_old_done", lat);
    chk("redirect_dropped", fetch_ready, 0);
    cycle();
    chk("redirect_valid", ext_valid, 1);
    chk("redirect_addr", ext_address, 32'h400);
    wait_for(1, "redirect_new_done", lat);
    cycle();
    fetch_request = 1'b0;
    cycle();

    // Store with slow slave
    slave_lat = 5;
    mem_address = 32'h9000; mem_write = 1'b1; mem_write_data = 32'hDEAD_BEEF;
    mem_strobe = 4'b0011; mem_request = 1'b1;
    push_grant(1'b1, 32'h9000, 32'hDEAD_BEEF, 4'b0011);
    push_resp(1'b0, rd_for(32'h9000));
    pulses0 = mem_ready_pulses;
    held = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #2;
      if (ext_valid && !ext_ready) held++;
      if (mem_ready) seen = 1'b1;
    end
    if (!seen) timeout("store_done");
    chk("store_hold_cycles", held, 5);
    cycle();
    mem_request = 1'b0; mem_write = 1'b0;
    cycle(); cycle();
    chk("store_single_ready", mem_ready_pulses - pulses0, 1);

    // Reset in the middle of a data transfer
    slave_lat = 10;
    fetch_address = 32'h600; fetch_request = 1'b1;
    mem_address = 32'hA000; mem_request = 1'b1;
    push_grant(1'b0, 32'hA000, 32'h0, 4'hF);
    cycle(); cycle();
    chk("prereset_valid", ext_valid, 1);
    chk("prereset_starve", dut.starve_cnt_reg, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("reset_async_valid", ext_valid, 0);
    chk("reset_state", dut.state_reg, IDLE);
    chk("reset_starve", dut.starve_cnt_reg, 0);
    fetch_request = 1'b0; mem_request = 1'b0;
    cycle(); cycle();
    reset = 1'b0;
    cycle();
    slave_lat = 1;
    mem_address = 32'hB000; mem_request = 1'b1;
    push_grant(1'b0, 32'hB000, 32'h0, 4'hF);
    push_resp(1'b0, rd_for(32'hB000));
    wait_for(0, "post_reset_load", lat);
    chk("post_reset_latency", lat, 2);
    cycle();
    mem_request = 1'b0;
    cycle(); cycle(); cycle();

    chk("grant_queue_empty", grant_q.size(), 0);
    chk("resp_queue_empty", resp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
